// File: rtl/half_pkg.sv
// ============================================================================
//  half_pkg
//  Shared half-precision types and scheduler state encoding.
//  Rev 1.0
// ============================================================================
`default_nettype none

package half_pkg;

    localparam int HALF_W = 16;

    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/half_mat_vec_sched.sv
// ============================================================================
//  half_mat_vec_sched
//  Drives one shared half dot-product engine across all matrix rows (y = M*x).
//  Rev 1.0
// ============================================================================
`default_nettype none

module half_mat_vec_sched
    import half_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int ROWS    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  half_t [ROWS-1:0][WIDTH-1:0]       matrix,
    input  half_t [WIDTH-1:0]                 vector,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output half_t [ROWS-1:0]                  result,
    output logic                              dot_start,
    output half_t [WIDTH-1:0]                 dot_vector_a,
    output half_t [WIDTH-1:0]                 dot_vector_b,
    input  logic                              dot_done,
    input  half_t                             dot_c
);

    localparam int c_ROW_W   = $clog2(ROWS) + 1;
    localparam int c_IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_TIMER_W = $clog2(TIMEOUT) + 1;

    localparam logic [c_ROW_W-1:0]   c_LAST_ROW = c_ROW_W'(ROWS - 1);
    localparam logic [c_TIMER_W-1:0] c_T_LIMIT  = c_TIMER_W'(TIMEOUT - 1);

    sched_state_t                     r_state;
    logic [c_ROW_W-1:0]               r_row;
    logic [c_TIMER_W-1:0]             r_timer;
    half_t [ROWS-1:0][WIDTH-1:0]      r_mat;
    half_t [WIDTH-1:0]                r_vec;
    half_t [ROWS-1:0]                 r_result;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_error;
    logic                             r_dot_start;

    logic [c_IDX_W-1:0]               w_row_idx;

    assign w_row_idx = r_row[c_IDX_W-1:0];

    // dot_start, done and busy are set on the edge that enters the matching
    // state, so each is high for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_timer     <= '0;
            r_mat       <= '0;
            r_vec       <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_dot_start <= 1'b0;
        end else begin
            r_dot_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mat       <= matrix;
                        r_vec       <= vector;
                        r_result    <= '0;
                        r_error     <= 1'b0;
                        r_row       <= '0;
                        r_timer     <= '0;
                        r_busy      <= 1'b1;
                        r_dot_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A completion in the final timeout cycle still counts.
                    if (dot_done) begin
                        r_result[w_row_idx] <= dot_c;
                        if (r_row == c_LAST_ROW) begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_row       <= r_row + 1'b1;
                            r_dot_start <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end else if (r_timer == c_T_LIMIT) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign result       = r_result;
    assign dot_start    = r_dot_start;
    assign dot_vector_a = r_mat[w_row_idx];
    assign dot_vector_b = r_vec;

endmodule

`default_nettype wire

// File: tb/tb_half_mat_vec_sched.sv
// ============================================================================
//  tb_half_mat_vec_sched
//  Directed bench with a behavioural dot engine for half_mat_vec_sched.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_half_mat_vec_sched;
    import half_pkg::*;

    localparam int W   = 10;
    localparam int R   = 4;
    localparam int LAT = 14;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    half_t [R-1:0][W-1:0] matrix;
    half_t [W-1:0]        vector;
    logic                 busy, done, error, dot_start, dot_done;
    half_t [R-1:0]        result;
    half_t [W-1:0]        dot_vector_a, dot_vector_b;
    half_t                dot_c;

    half_mat_vec_sched #(.WIDTH(W), .ROWS(R), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn), .start(start), .matrix(matrix), .vector(vector),
        .busy(busy), .done(done), .error(error), .result(result),
        .dot_start(dot_start), .dot_vector_a(dot_vector_a), .dot_vector_b(dot_vector_b),
        .dot_done(dot_done), .dot_c(dot_c)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Behavioural engine plus launch monitor
    half_t [R-1:0][W-1:0] exp_mat;
    half_t [W-1:0]        exp_vec;
    half_t                tab [0:3] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200};
    int    mode = 0;
    int    skip = -1;
    int    cnt  = 0;
    int    n_starts = 0;
    int    n_done   = 0;
    int    start_cyc [0:7];
    half_t pend;
    logic  m_done = 1'b0;
    logic  stray  = 1'b0;

    assign dot_done = m_done | stray;

    always @(negedge clk) begin
        if (!rstn) begin
            cnt    = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_done = 1'b1;
                    dot_c  = pend;
                end
            end
            if (dot_start) begin
                chk("one_outstanding", cnt, 0);
                if (n_starts < R) begin
                    chk("vec_a_row", dot_vector_a, exp_mat[n_starts]);
                    chk("vec_b", dot_vector_b, exp_vec);
                end
                if (n_starts < 8) start_cyc[n_starts] = cyc;
                pend = (mode == 0) ? 16'h4900 : tab[n_starts % 4];
                if (skip != n_starts) cnt = LAT;
                n_starts++;
            end
            if (done) n_done++;
        end
    end

    half_t [R-1:0][W-1:0] m_in;
    half_t [W-1:0]        v_in;
    int t0;
    bit hit;
    localparam logic [63:0] c_ONES = {4{16'h4900}};
    localparam logic [63:0] c_TAB  = {16'h4200, 16'h4000, 16'h3C00, 16'h0000};

    task automatic fill(input half_t base, input bit uniform);
        for (int r = 0; r < R; r++)
            for (int i = 0; i < W; i++)
                m_in[r][i] = uniform ? base : half_t'(base + r*16 + i);
        for (int i = 0; i < W; i++)
            v_in[i] = uniform ? base : half_t'(base + 16'h0100 + i);
    endtask

    // Called just after a falling edge; returns one falling edge later.
    task automatic launch();
        start    = 1'b1;
        matrix   = m_in;
        vector   = v_in;
        exp_mat  = m_in;
        exp_vec  = v_in;
        t0       = cyc;
        n_starts = 0;
        n_done   = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for(input bit use_err, output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (use_err ? error : done) begin
                got = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_gaps(input int n);
        for (int k = 0; k < n; k++)
            chk("start_cycle", start_cyc[k] - t0, 1 + 15*k);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; matrix = '0; vector = '0; dot_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_dot_start", dot_start, 0);
        chk("rst_result", result, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: all-ones operands, fixed engine answer 10.0
        mode = 0; fill(16'h3C00, 1'b1);
        launch();
        chk("t1_busy", busy, 1);
        wait_for(1'b0, hit);
        chk("t1_done_seen", hit, 1);
        chk("t1_done_cycle", cyc - t0, 61);
        chk("t1_busy_at_done", busy, 1);
        chk("t1_result", result, c_ONES);
        check_gaps(4);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        chk("t1_done_pulse", done, 0);
        chk("t1_nstarts", n_starts, 4);

        // 2: engine returns row index, distinct rows checked per launch
        mode = 1; fill(16'h1000, 1'b0);
        launch();
        wait_for(1'b0, hit);
        chk("t2_done_cycle", cyc - t0, 61);
        chk("t2_result", result, c_TAB);
        @(negedge clk);

        // 3: extra start during row 1 with changed inputs, stray dot_done in IDLE
        fill(16'h2000, 1'b0);
        launch();
        for (int i = 0; i < 100 && n_starts < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t3_in_wait", busy, 1);
        start = 1'b1; matrix = ~m_in; vector = ~v_in;
        @(negedge clk);
        start = 1'b0;
        wait_for(1'b0, hit);
        chk("t3_done_cycle", cyc - t0, 61);
        chk("t3_result", result, c_TAB);
        @(negedge clk);
        stray = 1'b1; dot_c = 16'h7777;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_stray_busy", busy, 0);
        chk("t3_stray_result", result, c_TAB);
        chk("t3_nstarts", n_starts, 4);
        chk("t3_ndone", n_done, 1);

        // 4: engine stalls on row 2
        skip = 2; fill(16'h3000, 1'b0);
        launch();
        wait_for(1'b1, hit);
        chk("t4_error_seen", hit, 1);
        chk("t4_error_cycle", cyc - t0, 96);
        chk("t4_busy", busy, 0);
        chk("t4_partial", result, {32'h0, 16'h3C00, 16'h0000});
        repeat (3) @(negedge clk);
        chk("t4_no_done", n_done, 0);
        chk("t4_nstarts", n_starts, 3);
        chk("t4_sticky", error, 1);
        skip = -1;
        launch();
        chk("t4_err_cleared", error, 0);
        wait_for(1'b0, hit);
        chk("t4_rerun_cycle", cyc - t0, 61);
        chk("t4_rerun_result", result, c_TAB);
        @(negedge clk);

        // 5: reset asserted while row 1 is in flight
        mode = 0; fill(16'h3C00, 1'b1);
        launch();
        for (int i = 0; i < 100 && n_starts < 2; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t5_pre_result", result[0], 16'h4900);
        rstn = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_dot_start", dot_start, 0);
        chk("t5_result", result, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        launch();
        wait_for(1'b0, hit);
        chk("t5_rerun_cycle", cyc - t0, 61);
        chk("t5_rerun_result", result, c_ONES);
        check_gaps(4);

        // 6: back-to-back start the cycle after done
        @(negedge clk);
        chk("t6_held", result, c_ONES);
        mode = 1; fill(16'h0500, 1'b0);
        launch();
        chk("t6_cleared", result, 0);
        wait_for(1'b0, hit);
        chk("t6_done_cycle", cyc - t0, 61);
        chk("t6_result", result, c_TAB);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
